// File: rtl/fetch_pkg.sv
// Constants and FSM encoding shared by the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs between the fetch
// engine and IF/ID; clear wins over push and pop.
module fetch_queue #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem
// requests, prefetch queue and redirect flushing.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [IW-1:0]   imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [IW-1:0]   out_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]        q_count;
    logic [XLEN+IW-1:0]   q_head;
    logic                 q_push;
    logic                 q_pop;
    logic [CW:0]          credit_used;
    logic                 req_fire;
    logic [XLEN-1:0]      redirect_tgt;
    logic                 unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];
    assign redirect_tgt    = {redirect_pc[XLEN-1:2], 2'b00};

    // Queued plus in-flight never exceeds DEPTH, so every
    // response is guaranteed a free slot.
    assign credit_used = {1'b0, q_count} + {1'b0, outstanding_q};

    assign imem_req_valid = (state_q == RUN) & ~redirect_valid
                          & (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign out_valid = (q_count != '0);
    assign q_push    = imem_rsp_valid & (state_q == RUN);
    assign q_pop     = out_valid & out_ready;

    fetch_queue #(
        .W     (XLEN + IW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (q_push),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
                if (imem_rsp_valid) rsp_pc_d = rsp_pc_q + XLEN'(4);
                outstanding_d = outstanding_q + CW'(req_fire)
                              - CW'(imem_rsp_valid);
            end
            FLUSH: begin
                if (imem_rsp_valid) drop_cnt_d = drop_cnt_q - 1'b1;
                if (drop_cnt_d == '0) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
        // A response landing on the redirect edge is already stale.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_tgt;
            rsp_pc_d      = redirect_tgt;
            drop_cnt_d    = outstanding_q + drop_cnt_q
                          - CW'(imem_rsp_valid);
            outstanding_d = '0;
            state_d       = (drop_cnt_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_pc   = out_valid ? q_head[XLEN+IW-1:IW] : '0;
    assign out_inst = out_valid ? q_head[IW-1:0] : IW'(NOP_INST);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: in-order memory model with latency, queue-level
// reference model, directed table and sequences, random traffic.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        bit          rst_n;
        bit          ov;
        logic [63:0] pc;
        bit          rv;
        logic [63:0] addr;
    } vec_t;

    mreq_t       mq[$];
    ent_t        q[$];
    logic [63:0] m_fetch;
    bit          m_boot;
    bit          m_known = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_err = 0;

    logic        s_ov, s_rv;
    logic [63:0] s_pc, s_addr;
    logic [31:0] s_inst;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic cycle(input bit rst_n, input bit rdr,
                         input logic [63:0] rpc,
                         input bit ordy, input bit qrdy);
        bit    rsp, e_ov, e_rv, fire, pop;
        int    stale_n;
        mreq_t r;
        @(negedge clk);
        reset          = rst_n;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        rsp = (mq.size() != 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
        #1;
        s_ov = out_valid; s_pc = out_pc; s_inst = out_inst;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        stale_n = 0;
        foreach (mq[i]) if (mq[i].stale) stale_n++;
        e_ov = (q.size() != 0);
        e_rv = !m_boot && (stale_n == 0) && !rdr
            && (q.size() + mq.size() - stale_n < DEPTH);
        if (m_known) begin
            check("out_valid", s_ov, e_ov);
            check("out_pc", s_pc, e_ov ? q[0].pc : 64'd0);
            check("out_inst", s_inst, e_ov ? q[0].inst : NOP_INST);
            check("req_valid", s_rv, e_rv);
            if (e_rv) check("req_addr", s_addr, m_fetch);
        end
        fire = e_rv && qrdy;
        pop  = e_ov && ordy;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mq.delete();
            m_fetch = 64'd0;
            m_boot  = 1;
            m_known = 1;
        end else begin
            m_boot = 0;
            if (rsp) r = mq.pop_front();
            if (rdr) begin
                q.delete();
                foreach (mq[i]) mq[i].stale = 1;
                m_fetch = {rpc[63:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (rsp && !r.stale)
                    q.push_back('{r.addr, mem_word(r.addr)});
                if (fire) begin
                    mq.push_back('{m_fetch, cyc + lat, 1'b0});
                    m_fetch = m_fetch + 64'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit ordy, input bit qrdy);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, ordy, qrdy);
    endtask

    task automatic wait_out(input int budget);
        int i = 0;
        do begin
            cycle(1, 0, 0, 1, 1);
            i++;
        end while (!s_ov && i < budget);
    endtask

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          rdr;
        logic [63:0] tgt;
        tbl[0] = '{0, 0, 64'd0,  0, 64'd0};
        tbl[1] = '{1, 0, 64'd0,  0, 64'd0};
        tbl[2] = '{1, 0, 64'd0,  1, 64'd0};
        tbl[3] = '{1, 0, 64'd0,  1, 64'd4};
        tbl[4] = '{1, 1, 64'd0,  1, 64'd8};
        tbl[5] = '{1, 1, 64'd4,  1, 64'd12};
        tbl[6] = '{1, 1, 64'd8,  1, 64'd16};
        tbl[7] = '{1, 1, 64'd12, 1, 64'd20};

        reset = 0; redirect_valid = 0; redirect_pc = 0;
        out_ready = 1; imem_req_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = 0;

        // 1: zero-wait memory, back-to-back stream
        lat = 1;
        cycle(0, 0, 0, 1, 1);
        foreach (tbl[i]) begin
            cycle(tbl[i].rst_n, 0, 0, 1, 1);
            check("t1_ov", s_ov, tbl[i].ov);
            check("t1_pc", s_pc, tbl[i].pc);
            check("t1_rv", s_rv, tbl[i].rv);
            if (tbl[i].rv) check("t1_addr", s_addr, tbl[i].addr);
            if (tbl[i].ov) check("t1_inst", s_inst, mem_word(tbl[i].pc));
            else check("t1_nop", s_inst, NOP_INST);
        end

        // 2: stalled consumer, credits exhausted, then drain
        cycle(0, 0, 0, 1, 1);
        lat = 2;
        run(12, 0, 1);
        check("t2_stop", s_rv, 0);
        check("t2_head_v", s_ov, 1);
        check("t2_head_pc", s_pc, 64'd0);
        run(20, 1, 1);

        // 3: redirect with three requests in flight
        cycle(0, 0, 0, 1, 1);
        lat = 5;
        run(4, 1, 1);
        cycle(1, 1, 64'h100, 1, 1);
        cycle(1, 0, 0, 1, 1);
        check("t3_flush_noreq", s_rv, 0);
        wait_out(40);
        check("t3_valid", s_ov, 1);
        check("t3_first_pc", s_pc, 64'h100);
        run(10, 1, 1);

        // 4: redirect with response and pop in the same cycle
        cycle(0, 0, 0, 1, 1);
        lat = 1;
        run(6, 1, 1);
        cycle(1, 1, 64'h400, 1, 1);
        check("t4_pre_ov", s_ov, 1);
        cycle(1, 0, 0, 1, 1);
        check("t4_empty", s_ov, 0);
        check("t4_req", s_rv, 1);
        check("t4_addr", s_addr, 64'h400);
        run(6, 1, 1);

        // 5: second redirect while flushing, low bits ignored
        cycle(0, 0, 0, 1, 1);
        lat = 3;
        run(5, 1, 1);
        cycle(1, 1, 64'h200, 1, 1);
        cycle(1, 1, 64'h302, 1, 1);
        wait_out(40);
        check("t5_valid", s_ov, 1);
        check("t5_first_pc", s_pc, 64'h300);
        run(6, 1, 1);

        // 6: reset mid-stream
        cycle(0, 0, 0, 1, 1);
        cycle(1, 0, 0, 1, 1);
        check("t6_ov", s_ov, 0);
        check("t6_nop", s_inst, NOP_INST);
        check("t6_boot_noreq", s_rv, 0);
        cycle(1, 0, 0, 1, 1);
        check("t6_restart_req", s_rv, 1);
        check("t6_restart_pc", s_addr, 64'd0);

        // random traffic, including PC wrap-around
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 299) == 0) begin
                cycle(0, 0, 0, 1, 1);
            end else begin
                rdr = !m_boot && ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0)
                    tgt = 64'hFFFF_FFFF_FFFF_FFE0
                        | 64'($urandom_range(0, 31));
                else
                    tgt = {$urandom, $urandom};
                cycle(1, rdr, tgt, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 3) != 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
